// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache client ports and the shared memory port.
// The arbiter takes the slave view; the caches and memory together form the master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] i_ic_addr;
  logic              i_ic_ren;
  logic              i_ic_wen;
  logic [DATA_W-1:0] i_ic_wdata;
  logic              o_ic_ready;
  logic [DATA_W-1:0] o_ic_rdata;
  logic              o_ic_valid;

  logic [ADDR_W-1:0] i_dc_addr;
  logic              i_dc_ren;
  logic              i_dc_wen;
  logic [DATA_W-1:0] i_dc_wdata;
  logic              o_dc_ready;
  logic [DATA_W-1:0] o_dc_rdata;
  logic              o_dc_valid;

  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_ren;
  logic              o_mem_wen;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_valid;

  modport slave (
    input  i_ic_addr, i_ic_ren, i_ic_wen, i_ic_wdata,
    output o_ic_ready, o_ic_rdata, o_ic_valid,
    input  i_dc_addr, i_dc_ren, i_dc_wen, i_dc_wdata,
    output o_dc_ready, o_dc_rdata, o_dc_valid,
    input  i_mem_ready, i_mem_rdata, i_mem_valid,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata
  );

  modport master (
    output i_ic_addr, i_ic_ren, i_ic_wen, i_ic_wdata,
    input  o_ic_ready, o_ic_rdata, o_ic_valid,
    output i_dc_addr, i_dc_ren, i_dc_wen, i_dc_wdata,
    input  o_dc_ready, o_dc_rdata, o_dc_valid,
    output i_mem_ready, i_mem_rdata, i_mem_valid,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting the icache and dcache share one word memory port,
// with a single outstanding transaction held in a holding register.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;          // last granted owner: 0 = icache, 1 = dcache
  logic              owner_q, owner_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic ic_req_s;
  logic dc_req_s;
  logic grant_ic_s;
  logic grant_dc_s;

  // Arbitration: sole requester wins, a tie goes to the client not granted last
  always_comb begin
    ic_req_s   = bus.i_ic_ren | bus.i_ic_wen;
    dc_req_s   = bus.i_dc_ren | bus.i_dc_wen;
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_dc_s = dc_req_s & (~ic_req_s | ~rr_q);
      grant_ic_s = ic_req_s & ~grant_dc_s;
    end else begin
      grant_dc_s = 1'b0;
      grant_ic_s = 1'b0;
    end
  end

  // State and holding register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and holding-register capture
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_dc_s) begin
          state_d = ST_ISSUE;
          rr_d    = 1'b1;
          owner_d = 1'b1;
          addr_d  = bus.i_dc_addr;
          wdata_d = bus.i_dc_wdata;
          // ren and wen together is treated as a read
          op_wr_d = bus.i_dc_wen & ~bus.i_dc_ren;
        end else if (grant_ic_s) begin
          state_d = ST_ISSUE;
          rr_d    = 1'b0;
          owner_d = 1'b0;
          addr_d  = bus.i_ic_addr;
          wdata_d = bus.i_ic_wdata;
          op_wr_d = bus.i_ic_wen & ~bus.i_ic_ren;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.i_mem_ready) begin
          state_d = op_wr_q ? ST_IDLE : ST_WAIT_RD;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_RD: begin
        if (bus.i_mem_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_RD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: strobes only in ISSUE, response routed to the owner only in WAIT_RD
  always_comb begin
    bus.o_ic_ready  = 1'b0;
    bus.o_dc_ready  = 1'b0;
    bus.o_ic_valid  = 1'b0;
    bus.o_dc_valid  = 1'b0;
    bus.o_mem_ren   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_addr  = addr_q;
    bus.o_mem_wdata = wdata_q;
    bus.o_ic_rdata  = bus.i_mem_rdata;
    bus.o_dc_rdata  = bus.i_mem_rdata;
    case (state_q)
      ST_IDLE: begin
        bus.o_ic_ready = grant_ic_s;
        bus.o_dc_ready = grant_dc_s;
      end
      ST_ISSUE: begin
        bus.o_mem_ren = ~op_wr_q;
        bus.o_mem_wen = op_wr_q;
      end
      ST_WAIT_RD: begin
        if (owner_q) begin
          bus.o_dc_valid = bus.i_mem_valid;
        end else begin
          bus.o_ic_valid = bus.i_mem_valid;
        end
      end
      default: begin
        bus.o_ic_ready = 1'b0;
        bus.o_dc_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, tie-break, round-robin,
// write with backpressure, stray valid and reset while waiting for read data.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic exp_dc;
  logic [31:0] exp_addr;
  int   ic_n;
  int   dc_n;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clients must never raise ren and wen together
  always @(negedge clk) begin
    assert (!(bus.i_ic_ren && bus.i_ic_wen) && !(bus.i_dc_ren && bus.i_dc_wen))
      else $error("FAIL illegal_ren_wen: both strobes high on one client");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.i_ic_addr = 32'h0; bus.i_ic_ren = 1'b0; bus.i_ic_wen = 1'b0; bus.i_ic_wdata = 32'h0;
    bus.i_dc_addr = 32'h0; bus.i_dc_ren = 1'b0; bus.i_dc_wen = 1'b0; bus.i_dc_wdata = 32'h0;
    bus.i_mem_ready = 1'b0; bus.i_mem_rdata = 32'h0; bus.i_mem_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_mem_ren", bus.o_mem_ren, 32'd0);
    check("rst_mem_wen", bus.o_mem_wen, 32'd0);
    check("rst_mem_addr", bus.o_mem_addr, 32'h0);
    check("rst_mem_wdata", bus.o_mem_wdata, 32'h0);
    check("rst_ic_ready", bus.o_ic_ready, 32'd0);
    check("rst_dc_ready", bus.o_dc_ready, 32'd0);
    check("rst_ic_valid", bus.o_ic_valid, 32'd0);
    check("rst_dc_valid", bus.o_dc_valid, 32'd0);

    // Single dcache read
    cyc();
    bus.i_dc_ren = 1'b1; bus.i_dc_addr = 32'h100;
    @(negedge clk);
    check("rd_dc_ready", bus.o_dc_ready, 32'd1);
    check("rd_ic_ready", bus.o_ic_ready, 32'd0);
    cyc();
    bus.i_dc_ren = 1'b0; bus.i_mem_ready = 1'b1;
    @(negedge clk);
    check("rd_mem_ren", bus.o_mem_ren, 32'd1);
    check("rd_mem_addr", bus.o_mem_addr, 32'h100);
    check("rd_issue_ready", bus.o_dc_ready, 32'd0);
    cyc();
    bus.i_mem_ready = 1'b0;
    @(negedge clk);
    check("rd_wait_ren", bus.o_mem_ren, 32'd0);
    check("rd_wait_valid", bus.o_dc_valid, 32'd0);
    cyc();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rd_dc_valid", bus.o_dc_valid, 32'd1);
    check("rd_dc_rdata", bus.o_dc_rdata, 32'hDEADBEEF);
    check("rd_ic_valid", bus.o_ic_valid, 32'd0);
    check("rd_ic_rdata", bus.o_ic_rdata, 32'hDEADBEEF);

    // Stray valid while idle
    cyc();
    @(negedge clk);
    check("stray_ic_valid", bus.o_ic_valid, 32'd0);
    check("stray_dc_valid", bus.o_dc_valid, 32'd0);
    cyc();
    bus.i_mem_valid = 1'b0;

    // Tie after reset: dcache first, then icache
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.i_ic_ren = 1'b1; bus.i_ic_addr = 32'h40;
    bus.i_dc_ren = 1'b1; bus.i_dc_addr = 32'h80;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    check("tie_dc_ready", bus.o_dc_ready, 32'd1);
    check("tie_ic_ready", bus.o_ic_ready, 32'd0);
    cyc();
    bus.i_dc_ren = 1'b0;
    @(negedge clk);
    check("tie_mem_addr0", bus.o_mem_addr, 32'h80);
    check("tie_ic_hold", bus.o_ic_ready, 32'd0);
    cyc();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h11110000;
    @(negedge clk);
    check("tie_dc_valid", bus.o_dc_valid, 32'd1);
    check("tie_ic_valid0", bus.o_ic_valid, 32'd0);
    cyc();
    bus.i_mem_valid = 1'b0;
    @(negedge clk);
    check("tie_ic_ready2", bus.o_ic_ready, 32'd1);
    cyc();
    bus.i_ic_ren = 1'b0;
    @(negedge clk);
    check("tie_mem_addr1", bus.o_mem_addr, 32'h40);
    check("tie_mem_ren1", bus.o_mem_ren, 32'd1);
    cyc();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h22220000;
    @(negedge clk);
    check("tie_ic_valid", bus.o_ic_valid, 32'd1);
    check("tie_ic_rdata", bus.o_ic_rdata, 32'h22220000);
    check("tie_dc_valid1", bus.o_dc_valid, 32'd0);
    cyc();

    // Round-robin: four reads each, memory always ready and valid
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'hA5A50000;
    bus.i_ic_ren = 1'b1; bus.i_ic_addr = 32'h200;
    bus.i_dc_ren = 1'b1; bus.i_dc_addr = 32'h300;
    ic_n = 0; dc_n = 0;
    for (int t = 0; t < 8; t++) begin
      exp_dc = (t % 2 == 0);
      @(negedge clk);
      check("rr_dc_ready", bus.o_dc_ready, {31'd0, exp_dc});
      check("rr_ic_ready", bus.o_ic_ready, {31'd0, ~exp_dc});
      check("rr_idle_valid", {30'd0, bus.o_ic_valid, bus.o_dc_valid}, 32'd0);
      exp_addr = exp_dc ? bus.i_dc_addr : bus.i_ic_addr;
      cyc();
      if (exp_dc) begin
        dc_n++;
        bus.i_dc_addr = bus.i_dc_addr + 32'h4;
        if (dc_n == 4) bus.i_dc_ren = 1'b0;
      end else begin
        ic_n++;
        bus.i_ic_addr = bus.i_ic_addr + 32'h4;
        if (ic_n == 4) bus.i_ic_ren = 1'b0;
      end
      @(negedge clk);
      check("rr_mem_addr", bus.o_mem_addr, exp_addr);
      check("rr_mem_ren", bus.o_mem_ren, 32'd1);
      cyc();
      @(negedge clk);
      check("rr_owner_valid", exp_dc ? bus.o_dc_valid : bus.o_ic_valid, 32'd1);
      check("rr_other_valid", exp_dc ? bus.o_ic_valid : bus.o_dc_valid, 32'd0);
      cyc();
    end
    bus.i_mem_valid = 1'b0;

    // Icache write under backpressure
    bus.i_mem_ready = 1'b0;
    bus.i_ic_wen = 1'b1; bus.i_ic_addr = 32'h10; bus.i_ic_wdata = 32'h12345678;
    @(negedge clk);
    check("wr_ic_ready", bus.o_ic_ready, 32'd1);
    cyc();
    bus.i_ic_wen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wr_mem_wen", bus.o_mem_wen, 32'd1);
      check("wr_mem_ren", bus.o_mem_ren, 32'd0);
      check("wr_mem_addr", bus.o_mem_addr, 32'h10);
      check("wr_mem_wdata", bus.o_mem_wdata, 32'h12345678);
      cyc();
    end
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    check("wr_accept_wen", bus.o_mem_wen, 32'd1);
    cyc();
    bus.i_dc_ren = 1'b1; bus.i_dc_addr = 32'h500;
    @(negedge clk);
    check("wr_done_wen", bus.o_mem_wen, 32'd0);
    check("wr_no_valid", bus.o_ic_valid, 32'd0);
    check("wr_idle_ready", bus.o_dc_ready, 32'd1);

    // Reset while waiting for read data
    cyc();
    bus.i_dc_ren = 1'b0;
    @(negedge clk);
    check("rw_mem_addr", bus.o_mem_addr, 32'h500);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rw_wait_valid", bus.o_dc_valid, 32'd0);
    cyc();
    rst = 1'b0;
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rw_dc_valid", bus.o_dc_valid, 32'd0);
    check("rw_ic_valid", bus.o_ic_valid, 32'd0);
    check("rw_mem_ren", bus.o_mem_ren, 32'd0);
    check("rw_mem_addr0", bus.o_mem_addr, 32'h0);
    cyc();
    bus.i_mem_valid = 1'b0;
    bus.i_dc_ren = 1'b1; bus.i_dc_addr = 32'h600;
    @(negedge clk);
    check("rw_dc_ready", bus.o_dc_ready, 32'd1);
    cyc();
    bus.i_dc_ren = 1'b0;
    @(negedge clk);
    check("rw_mem_addr1", bus.o_mem_addr, 32'h600);
    check("rw_mem_ren1", bus.o_mem_ren, 32'd1);
    cyc();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h0BADCAFE;
    @(negedge clk);
    check("rw_dc_valid1", bus.o_dc_valid, 32'd1);
    check("rw_dc_rdata1", bus.o_dc_rdata, 32'h0BADCAFE);
    cyc();
    bus.i_mem_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
